// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, one bit per cycle LSB first; done arrives WIDTH+1 cycles after the accepting edge.
// Backpressure: ready is low outside IDLE, and a start seen while ready is low is dropped.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Holds the upper WIDTH-1 result bits; the incoming bit completes the word.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d;
  logic             a_msb, b_msb;
  logic             last;

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_nxt = {d, res_sh};
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_nxt[WIDTH-1:1];
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          // The final bit is d itself, so the sign of the result is known here.
          if (last) begin
            diff <= res_nxt;
            bout <= br_nxt;
            ovf  <= (a_msb != b_msb) && (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2 to 32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled only when ready is high.
REQ-005 Port: a  input  WIDTH  minuend, captured on the accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend, captured on the accepted start.
REQ-007 Port: bin  input  1  borrow-in, captured on the accepted start.
REQ-008 Port: ready  output  1  high when a start will be accepted.
REQ-009 Port: busy  output  1  high while bit-serial computation is in progress.
REQ-010 Port: done  output  1  single-cycle pulse marking valid results.
REQ-011 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  borrow-out; high when unsigned a < b + bin.
REQ-013 Port: ovf  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-014 The block SHALL be an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE, ready SHALL be 1, busy SHALL be 0 and done SHALL be 0.
REQ-016 On start=1 in IDLE, the block SHALL capture a, b and bin into internal shift and borrow registers.
REQ-017 On the same accepted start, the block SHALL clear a bit counter to 0 and enter RUN on the next edge.
REQ-018 In RUN, each cycle SHALL process exactly one bit, LSB first, through a 1-bit full-subtractor cell.
REQ-019 The full-subtractor cell SHALL compute d = ai ^ bi ^ br and br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-020 In RUN, each cycle SHALL shift d into the MSB of the result shift register, update the borrow flop, and increment the counter.
REQ-021 RUN SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1, the FSM SHALL enter DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be WIDTH+1 cycles from the edge that accepts start to the cycle in which done is high.
REQ-024 In RUN and DONE, ready SHALL be 0 and busy SHALL equal (state == RUN).
REQ-025 A start asserted while in RUN or DONE SHALL be ignored, with no effect on the results.
REQ-026 diff, bout and ovf SHALL be updated only on the transition into DONE.
REQ-027 diff, bout and ovf SHALL hold their values from DONE until the next transition into DONE or until reset.
REQ-028 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-029 Changes on a, b or bin after capture SHALL NOT affect the operation in progress.
REQ-030 Back-to-back operation is permitted: a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-031 Under back-to-back operation, consecutive done pulses SHALL be WIDTH+2 cycles apart.

Reset
REQ-032 While rst=1 at a clock edge, state SHALL become IDLE, and the counter, shift registers and borrow flop SHALL clear to 0.
REQ-033 Reset SHALL set diff=0, bout=0, ovf=0, done=0, busy=0 and ready=1 on the next edge.
REQ-034 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and previous results SHALL be lost.
REQ-035 start asserted together with rst SHALL be ignored.

Verification
REQ-036 Basic subtraction: WIDTH=8, a=0x05, b=0x03, bin=0, start -> done exactly 9 cycles later; diff=0x02, bout=0, ovf=0.
REQ-037 Unsigned underflow: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
REQ-038 Borrow-in: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0; then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-039 Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-040 Handshake: start held high continuously from cycle 0 with operands changing every cycle -> ready low during RUN and DONE; each result matches the operands present at its accepting edge; done pulses every 10 cycles.
REQ-041 Reset mid-operation: rst=1 for one cycle at the 4th RUN cycle -> no done pulse, all outputs 0, ready=1; a subsequent 0x05-0x03 operation yields diff=0x02.
